// File: rtl/exe_seq_ctrl.sv
// -----------------------------------------------------------------------------
// exe_seq_ctrl
//
// Command sequencer for the four-operation execution unit (subtract, compare,
// shift, bit change). Host commands are buffered in a small FIFO and issued
// one at a time to the unit's registered inputs. The result and status are
// captured once the unit's one-cycle register latency has elapsed, then held
// on a valid/ready result port. Supports chaining, where the last captured
// result replaces operand A, and sticky error tracking.
//
// Optional feature macro: EXE_SEQ_HALT_ON_ERR_EN
//   defined   : a consumed result with the ERROR bit set stops issuing (HALT)
//               until i_err_clr is pulsed; queued commands are kept.
//   undefined : errors only set o_err_sticky; issuing never stops.
//
// Parameters
//   BITS      operand/result width (must match the execution unit)
//   DEPTH     command FIFO entries (power of two, >= 2)
//   ERROR_BIT position of the ERROR flag in the unit's status (macros.hv)
//
// Ports
//   i_clk, i_rst          clock, asynchronous active-low reset
//   i_cmd_valid/o_cmd_ready, i_cmd_op/a/b/chain   command push interface
//   o_exe_a/b/op          operands and opcode driven to the execution unit
//   i_exe_out/status      registered result and status from the unit
//   o_res_valid/i_res_ready, o_res_data/status    result handshake
//   o_err_sticky, i_err_clr                       sticky error flag / clear
//   o_busy                sequencer active or commands pending
// -----------------------------------------------------------------------------
module exe_seq_ctrl #(
    parameter int BITS      = 8,
    parameter int DEPTH     = 4,
    parameter int ERROR_BIT = 1
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_cmd_valid,
    output logic            o_cmd_ready,
    input  logic [1:0]      i_cmd_op,
    input  logic [BITS-1:0] i_cmd_a,
    input  logic [BITS-1:0] i_cmd_b,
    input  logic            i_cmd_chain,
    output logic [BITS-1:0] o_exe_a,
    output logic [BITS-1:0] o_exe_b,
    output logic [1:0]      o_exe_op,
    input  logic [BITS-1:0] i_exe_out,
    input  logic [3:0]      i_exe_status,
    output logic            o_res_valid,
    input  logic            i_res_ready,
    output logic [BITS-1:0] o_res_data,
    output logic [3:0]      o_res_status,
    output logic            o_err_sticky,
    input  logic            i_err_clr,
    output logic            o_busy
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int EW = 2 + BITS + BITS + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ISSUE = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_HOLD  = 3'd3;
    localparam logic [2:0] S_HALT  = 3'd4;

    // Command FIFO storage: each entry is {op, a, b, chain}
    logic [EW-1:0]   r_mem [DEPTH];
    logic [PW-1:0]   r_wptr;
    logic [PW-1:0]   r_rptr;
    logic [CW-1:0]   r_count;

    logic [2:0]      r_state;
    logic [BITS-1:0] r_exe_a;
    logic [BITS-1:0] r_exe_b;
    logic [1:0]      r_exe_op;
    logic            r_res_valid;
    logic [BITS-1:0] r_res_data;
    logic [3:0]      r_res_status;
    logic            r_err_sticky;

    logic            w_push;
    logic            w_pop;
    logic            w_not_empty;
    logic            w_halt_go;
    logic [EW-1:0]   w_head;
    logic [1:0]      w_head_op;
    logic [BITS-1:0] w_head_a;
    logic [BITS-1:0] w_head_b;
    logic            w_head_chain;

    // Ready depends only on the registered count, so a same-cycle pop never
    // lets a full FIFO accept (no bypass path).
    assign o_cmd_ready = (r_count != FULL_CNT);
    assign w_push      = i_cmd_valid && o_cmd_ready;
    assign w_not_empty = (r_count != '0);

    assign w_head = r_mem[r_rptr];
    assign {w_head_op, w_head_a, w_head_b, w_head_chain} = w_head;

`ifdef EXE_SEQ_HALT_ON_ERR_EN
    // The decision is taken on the result being consumed, held in r_res_status.
    assign w_halt_go = r_res_status[ERROR_BIT];
`else
    assign w_halt_go = 1'b0;
`endif

    // A command leaves the FIFO either straight from IDLE or back-to-back when
    // the previous result is consumed and no halt is pending.
    assign w_pop = w_not_empty &&
                   ((r_state == S_IDLE) ||
                    ((r_state == S_HOLD) && i_res_ready && !w_halt_go));

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= {i_cmd_op, i_cmd_a, i_cmd_b, i_cmd_chain};
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    // Sequencer: loading the operands happens on the pop itself, so the unit
    // registers them on the following edge (ISSUE) and its output is ready to
    // be captured one edge later (WAIT).
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state      <= S_IDLE;
            r_exe_a      <= '0;
            r_exe_b      <= '0;
            r_exe_op     <= '0;
            r_res_valid  <= 1'b0;
            r_res_data   <= '0;
            r_res_status <= '0;
        end else begin
            if (w_pop) begin
                r_exe_op <= w_head_op;
                r_exe_b  <= w_head_b;
                r_exe_a  <= w_head_chain ? r_res_data : w_head_a;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    r_res_data   <= i_exe_out;
                    r_res_status <= i_exe_status;
                    r_res_valid  <= 1'b1;
                    r_state      <= S_HOLD;
                end
                S_HOLD: begin
                    if (i_res_ready) begin
                        r_res_valid <= 1'b0;
                        if (w_halt_go) begin
                            r_state <= S_HALT;
                        end else if (w_pop) begin
                            r_state <= S_ISSUE;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                S_HALT: begin
                    if (i_err_clr) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Setting wins over a coincident clear so an error is never lost.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_err_sticky <= 1'b0;
        end else if ((r_state == S_WAIT) && i_exe_status[ERROR_BIT]) begin
            r_err_sticky <= 1'b1;
        end else if (i_err_clr) begin
            r_err_sticky <= 1'b0;
        end
    end

    assign o_exe_a      = r_exe_a;
    assign o_exe_b      = r_exe_b;
    assign o_exe_op     = r_exe_op;
    assign o_res_valid  = r_res_valid;
    assign o_res_data   = r_res_data;
    assign o_res_status = r_res_status;
    assign o_err_sticky = r_err_sticky;
    assign o_busy       = (r_state != S_IDLE) || w_not_empty;

endmodule

// File: tb/tb_exe_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_exe_seq_ctrl
//
// Self-checking bench for exe_seq_ctrl. A behavioural execution-unit model
// answers the sequencer with a one-cycle registered result. A reference model
// computes the expected result of every accepted command in command order
// (chaining from the previous expected result) and queues it; every consumed
// result is compared against the head of that queue. Directed sequences cover
// latency, chaining, FIFO fill/wrap, backpressure, error handling and reset.
// -----------------------------------------------------------------------------
module tb_exe_seq_ctrl;

    localparam int BITS       = 8;
    localparam int DEPTH      = 4;
    localparam int OVF_BIT    = 0;
    localparam int ERROR_BIT  = 1;
    localparam int EVEN_BIT   = 2;
    localparam int SINGLE_BIT = 3;

    logic            clk = 1'b0;
    logic            rstN = 1'b0;
    logic            cmdValid = 1'b0;
    logic            cmdReady;
    logic [1:0]      cmdOp = '0;
    logic [BITS-1:0] cmdA = '0;
    logic [BITS-1:0] cmdB = '0;
    logic            cmdChain = 1'b0;
    logic [BITS-1:0] exeA;
    logic [BITS-1:0] exeB;
    logic [1:0]      exeOp;
    logic [BITS-1:0] exeOut = '0;
    logic [3:0]      exeStatus = '0;
    logic            resValid;
    logic            resReady = 1'b1;
    logic [BITS-1:0] resData;
    logic [3:0]      resStatus;
    logic            errSticky;
    logic            errClr = 1'b0;
    logic            busy;

    int              errCount = 0;
    int              checkCount = 0;
    logic [11:0]     expQ [$];
    logic [7:0]      refPrev = '0;
    logic [7:0]      lastRes = '0;
    logic [7:0]      monA;
    logic [11:0]     monR;

    always #5 clk = ~clk;

    exe_seq_ctrl #(.BITS(BITS), .DEPTH(DEPTH), .ERROR_BIT(ERROR_BIT)) dut (
        .i_clk        (clk),
        .i_rst        (rstN),
        .i_cmd_valid  (cmdValid),
        .o_cmd_ready  (cmdReady),
        .i_cmd_op     (cmdOp),
        .i_cmd_a      (cmdA),
        .i_cmd_b      (cmdB),
        .i_cmd_chain  (cmdChain),
        .o_exe_a      (exeA),
        .o_exe_b      (exeB),
        .o_exe_op     (exeOp),
        .i_exe_out    (exeOut),
        .i_exe_status (exeStatus),
        .o_res_valid  (resValid),
        .i_res_ready  (resReady),
        .o_res_data   (resData),
        .o_res_status (resStatus),
        .o_err_sticky (errSticky),
        .i_err_clr    (errClr),
        .o_busy       (busy)
    );

    // Behaviour of the execution unit: returns {status, result}.
    function automatic logic [11:0] unitFn(input logic [1:0] op, input logic [7:0] a,
                                           input logic [7:0] b);
        logic [7:0] r;
        logic [3:0] st;
        logic       ovf;
        logic       err;
        ovf = 1'b0;
        err = 1'b0;
        case (op)
            2'b00: begin r = a - b; ovf = (a < b); end
            2'b01: r = (a == b) ? 8'h00 : ((a > b) ? 8'h01 : 8'hFF);
            2'b10: begin r = a << b[2:0]; err = (b >= 8'd8); end
            default: begin r = a ^ (8'h01 << b[2:0]); err = (b >= 8'd8); end
        endcase
        st = '0;
        st[OVF_BIT]    = ovf;
        st[ERROR_BIT]  = err;
        st[EVEN_BIT]   = ~r[0];
        st[SINGLE_BIT] = $onehot(r);
        return {st, r};
    endfunction

    // Registered execution unit model: one cycle from operands to result.
    always @(posedge clk) begin
        {exeStatus, exeOut} <= unitFn(exeOp, exeA, exeB);
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Reference model and result scoreboard, sampled mid-cycle.
    always @(negedge clk) begin
        if (rstN) begin
            if (cmdValid && cmdReady) begin
                monA = cmdChain ? refPrev : cmdA;
                monR = unitFn(cmdOp, monA, cmdB);
                refPrev = monR[7:0];
                expQ.push_back(monR);
            end
            if (resValid && resReady) begin
                checkOutput("resultPending", 32'(expQ.size() != 0), 32'd1);
                if (expQ.size() != 0) begin
                    checkOutput("resultData", {20'd0, resStatus, resData}, {20'd0, expQ[0]});
                    void'(expQ.pop_front());
                end
                lastRes = resData;
            end
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [1:0] op, input logic [7:0] a,
                                 input logic [7:0] b, input logic chain);
        logic accepted;
        accepted = 1'b0;
        cmdValid = 1'b1;
        cmdOp    = op;
        cmdA     = a;
        cmdB     = b;
        cmdChain = chain;
        for (int i = 0; i < 50 && !accepted; i++) begin
            accepted = cmdReady;
            cycle();
        end
        cmdValid = 1'b0;
        checkOutput("pushAccepted", 32'(accepted), 32'd1);
    endtask

    task automatic drain(input int bound);
        resReady = 1'b1;
        for (int i = 0; i < bound && (expQ.size() != 0 || busy); i++) begin
            errClr = (i % 8 == 7);
            cycle();
        end
        errClr = 1'b0;
        checkOutput("drainedQueue", 32'(expQ.size()), 32'd0);
        checkOutput("drainedIdle", 32'(busy), 32'd0);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "CmdReady"}, 32'(cmdReady), 32'd1);
        checkOutput({tag, "ExeA"}, 32'(exeA), 32'd0);
        checkOutput({tag, "ExeB"}, 32'(exeB), 32'd0);
        checkOutput({tag, "ExeOp"}, 32'(exeOp), 32'd0);
        checkOutput({tag, "ResValid"}, 32'(resValid), 32'd0);
        checkOutput({tag, "ResData"}, 32'(resData), 32'd0);
        checkOutput({tag, "ResStatus"}, 32'(resStatus), 32'd0);
        checkOutput({tag, "ErrSticky"}, 32'(errSticky), 32'd0);
        checkOutput({tag, "Busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int n;
        int acc;
        logic sawValid;
        logic [12:0] resSnap;
        logic [17:0] exeSnap;

        repeat (3) cycle();
        checkResetValues("reset");
        rstN = 1'b1;
        cycle();

        // Single subtract: valid appears three edges after the accepting edge.
        applyStimulus(2'b00, 8'h10, 8'h03, 1'b0);
        n = 0;
        while (!resValid && n < 20) begin
            cycle();
            n++;
        end
        checkOutput("latency", 32'(n), 32'd3);
        checkOutput("subData", 32'(resData), 32'h0D);
        checkOutput("subOvf", 32'(resStatus[OVF_BIT]), 32'd0);
        checkOutput("subErr", 32'(resStatus[ERROR_BIT]), 32'd0);
        drain(50);

        // Chaining uses the previous result as operand A.
        applyStimulus(2'b00, 8'h20, 8'h05, 1'b0);
        applyStimulus(2'b00, 8'hAA, 8'h01, 1'b1);
        drain(50);
        checkOutput("chainLast", 32'(lastRes), 32'h1A);

        // Fill the FIFO with the consumer stalled.
        resReady = 1'b0;
        acc = 0;
        cmdValid = 1'b1;
        for (int i = 0; i < DEPTH + 3; i++) begin
            cmdOp    = 2'b00;
            cmdA     = 8'h40 + 8'(i);
            cmdB     = 8'(i);
            cmdChain = 1'b0;
            if (cmdReady) acc++;
            cycle();
        end
        cmdValid = 1'b0;
        checkOutput("fillAccepts", 32'(acc), 32'(DEPTH + 1));
        checkOutput("fillReady", 32'(cmdReady), 32'd0);
        checkOutput("fillValid", 32'(resValid), 32'd1);

        // Backpressure: result and issued operands stay frozen.
        resSnap = {resValid, resStatus, resData};
        exeSnap = {exeOp, exeA, exeB};
        for (int i = 0; i < 5; i++) begin
            cycle();
            checkOutput("holdResult", 32'({resValid, resStatus, resData}), 32'(resSnap));
            checkOutput("holdExe", 32'({exeOp, exeA, exeB}), 32'(exeSnap));
        end
        drain(100);

        // Error result followed by a valid subtract.
        checkOutput("stickyBefore", 32'(errSticky), 32'd0);
        applyStimulus(2'b10, 8'h05, 8'h09, 1'b0);
        applyStimulus(2'b00, 8'h30, 8'h10, 1'b0);
        n = 0;
        while (!resValid && n < 20) begin
            cycle();
            n++;
        end
        checkOutput("errResultValid", 32'(resValid), 32'd1);
        checkOutput("stickySet", 32'(errSticky), 32'd1);
        n = 0;
        do begin
            cycle();
            n++;
        end while (!resValid && n < 12);
`ifdef EXE_SEQ_HALT_ON_ERR_EN
        checkOutput("haltWithheld", 32'(resValid), 32'd0);
        checkOutput("haltBusy", 32'(busy), 32'd1);
        errClr = 1'b1;
        cycle();
        errClr = 1'b0;
        checkOutput("stickyCleared", 32'(errSticky), 32'd0);
        n = 0;
        while (!resValid && n < 12) begin
            cycle();
            n++;
        end
        checkOutput("resumeValid", 32'(resValid), 32'd1);
`else
        checkOutput("errGap", 32'(n), 32'd3);
        errClr = 1'b1;
        cycle();
        errClr = 1'b0;
        checkOutput("stickyCleared", 32'(errSticky), 32'd0);
`endif
        drain(50);

        // Reset while a command is in WAIT with two more queued.
        resReady = 1'b0;
        applyStimulus(2'b00, 8'h55, 8'h11, 1'b0);
        applyStimulus(2'b00, 8'h66, 8'h22, 1'b0);
        applyStimulus(2'b00, 8'h77, 8'h33, 1'b0);
        rstN = 1'b0;
        expQ.delete();
        refPrev = '0;
        #1;
        checkResetValues("midReset");
        cycle();
        cycle();
        rstN = 1'b1;
        resReady = 1'b1;
        sawValid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            sawValid = sawValid | resValid;
        end
        checkOutput("noResultAfterReset", 32'(sawValid), 32'd0);
        checkOutput("idleAfterReset", 32'(busy), 32'd0);

        // Randomized traffic against the reference queue.
        for (int i = 0; i < 400; i++) begin
            cmdValid = ($urandom % 2) == 0;
            cmdOp    = 2'($urandom % 4);
            cmdA     = 8'($urandom);
            cmdB     = (($urandom % 4) == 0) ? 8'($urandom) : 8'($urandom_range(0, 9));
            cmdChain = ($urandom % 3) == 0;
            resReady = ($urandom % 4) != 0;
            errClr   = ($urandom % 10) == 0;
            cycle();
        end
        cmdValid = 1'b0;
        errClr   = 1'b0;
        drain(2000);

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule

// File: doc/exe_seq_ctrl.md
# exe_seq_ctrl

Command sequencer for the four-operation execution unit (subtract, compare, shift, bit change). Buffers operation commands from a host in a small FIFO, issues them one at a time to the execution unit's registered inputs, captures result and 4-bit status after the unit's one-cycle register latency, and presents them on a valid/ready result port. Supports chaining (previous result as operand A) and sticky error tracking.

## Interface
- BITS, 8, operand/result width; must match the execution unit
- DEPTH, 4, command FIFO entries; power of two, ≥ 2

- i_clk  in  1  clock
- i_rst  in  1  reset, asynchronous, active-low
- i_cmd_valid  in  1  command offered
- o_cmd_ready  out  1  FIFO can accept (= not full)
- i_cmd_op  in  2  operation code: 00 sub, 01 compare, 10 shift, 11 bit change
- i_cmd_a  in  BITS  operand A (ignored when chained)
- i_cmd_b  in  BITS  operand B
- i_cmd_chain  in  1  use last captured result as operand A
- o_exe_a  out  BITS  to execution unit i_a
- o_exe_b  out  BITS  to execution unit i_b
- o_exe_op  out  2  to execution unit i_op
- i_exe_out  in  BITS  from execution unit o_out
- i_exe_status  in  4  from execution unit o_status; bit positions per `OVF_BIT`, `ERROR_BIT`, `EVEN_BIT`, `SINGLE_BIT` in macros.hv
- o_res_valid  out  1  result available
- i_res_ready  in  1  consumer accepts result
- o_res_data  out  BITS  captured result (also the chain register)
- o_res_status  out  4  captured status
- o_err_sticky  out  1  set by any captured result with ERROR bit
- i_err_clr  in  1  clears o_err_sticky; releases HALT
- o_busy  out  1  state ≠ IDLE or FIFO non-empty

## Operation
- FIFO push on i_cmd_valid && o_cmd_ready; stores {op, a, b, chain}. No bypass; full FIFO deasserts ready even if a pop occurs same cycle.
- States: IDLE, ISSUE, WAIT, HOLD, HALT.
- IDLE: FIFO non-empty → pop head, load o_exe_op/o_exe_b, o_exe_a = chain ? o_res_data : a; → ISSUE.
- ISSUE: execution unit registers operands this edge → WAIT.
- WAIT: capture i_exe_out → o_res_data, i_exe_status → o_res_status, set o_res_valid; ERROR bit set → set o_err_sticky → HOLD.
- HOLD: on i_res_ready: clear o_res_valid; then HALT if halt condition (see Configuration), else FIFO non-empty → pop/load → ISSUE, else → IDLE.
- HALT: no issue; FIFO still accepts pushes; i_err_clr → IDLE.
- o_exe_* hold last loaded values between commands.
- o_res_data retains value after consumption (chain source). Chain on first command after reset uses 0.
- o_err_sticky: set-wins if capture with ERROR and i_err_clr coincide.

## Timing
- Reset (async assert, sync-to-clock release): state IDLE, FIFO empty, o_cmd_ready 1, o_exe_a/b/op 0, o_res_valid 0, o_res_data 0, o_res_status 0, o_err_sticky 0, o_busy 0. Reset mid-operation discards FIFO contents and in-flight result.
- Latency: command accepted at edge 0 into empty FIFO with IDLE → load at edge 1 → unit registers at edge 2 → o_res_valid high after edge 3.
- Throughput with i_res_ready held 1: one result per 3 cycles (valid high 1 cycle, low 2).
- o_res_valid, o_res_data, o_res_status stable while valid && !ready.
- FIFO full at DEPTH entries; read/write pointers wrap modulo DEPTH; count width $clog2(DEPTH+1).

## Configuration
- EXE_SEQ_HALT_ON_ERR_EN defined: a consumed result whose ERROR bit was set sends HOLD → HALT; issue stops until i_err_clr; queued commands preserved and resume in order.
- Undefined: HALT unreachable; errors only set o_err_sticky; issuing continues.

## Test plan
- Single sub a=8'h10, b=8'h03, ready=1 → o_res_valid 3 cycles after accept, o_res_data 8'h0D, OVF 0, ERROR 0.
- Chain: sub 8'h20−8'h05, then chained sub b=8'h01 → results 8'h1B then 8'h1A.
- Fill FIFO with DEPTH+1 back-to-back pushes, i_res_ready=0 → o_cmd_ready drops after DEPTH (plus one popped) accepts; results drain in order once ready=1, no loss or duplication across pointer wrap.
- Backpressure: hold i_res_ready=0 for 5 cycles → o_res_* stable, no new issue on o_exe_*.
- Error op (unit returns ERROR=1) followed by valid sub → o_err_sticky 1; with EXE_SEQ_HALT_ON_ERR_EN second result withheld until i_err_clr pulse, without it second result follows in 3 cycles.
- Assert i_rst low during WAIT with 2 commands queued → all outputs at reset values immediately, no result emitted after release.
